watch_mode_controller: RTL and testbench

//  User-interface sequencer for the combined watch/stopwatch datapath. Debounces three push buttons,

---
 rtl/watch_mode_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_watch_mode_controller.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_mode_controller.sv
// rtl/watch_mode_controller.sv - button debounce, mode sequencer and display scan for the watch/stopwatch pair
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   btn_mode       raw button: cycle CLOCK -> STOPWATCH -> SET_HOUR -> SET_MIN
//   btn_a          raw button: start/stop (stopwatch view), increment (set views)
//   btn_b          raw button: clear (stopped stopwatch), zero seconds (set views)
//   hour2..sec1    clock time digits (BCD, narrow tens digits)
//   min2_q..point1_q stopwatch digits (BCD, narrow tens digits)
//   start_stop     stopwatch run level
//   clear          one-cycle stopwatch clear pulse
//   hour_inc       one-cycle clock hour increment pulse
//   min_inc        one-cycle clock minute increment pulse
//   sec_zero       one-cycle clock seconds zero pulse
//   mode           0=CLOCK 1=STOPWATCH 2=SET_HOUR 3=SET_MIN
//   digit_sel      one-hot active digit, bit5 leftmost
//   digit_val      BCD of active digit, 4'hF blanks it
module watch_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCAN_CYCLES     = 50000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic [1:0] hour2,
    input  logic [3:0] hour1,
    input  logic [2:0] min2,
    input  logic [3:0] min1,
    input  logic [2:0] sec2,
    input  logic [3:0] sec1,
    input  logic [2:0] min2_q,
    input  logic [3:0] min1_q,
    input  logic [2:0] sec2_q,
    input  logic [3:0] sec1_q,
    input  logic [3:0] point1_q,
    output logic       start_stop,
    output logic       clear,
    output logic       hour_inc,
    output logic       min_inc,
    output logic       sec_zero,
    output logic [1:0] mode,
    output logic [5:0] digit_sel,
    output logic [3:0] digit_val
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SC_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    typedef enum logic [1:0] {
        CLOCK     = 2'd0,
        STOPWATCH = 2'd1,
        SET_HOUR  = 2'd2,
        SET_MIN   = 2'd3
    } mode_t;

    // Button vector ordering: bit0 = a, bit1 = b, bit2 = mode
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      accepted;
    logic [2:0]      accepted_d;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    assign raw = {btn_mode, btn_b, btn_a};

    // The counter only advances while the synchronized level disagrees with
    // the accepted level, so any glitch that returns early restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= '0;
            sync2      <= '0;
            accepted   <= '0;
            accepted_d <= '0;
            press      <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            accepted_d <= accepted;
            press      <= accepted & ~accepted_d;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != accepted[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        accepted[i] <= sync2[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    mode_t state;
    mode_t state_next;
    logic  start_stop_next;
    logic  clear_next;
    logic  hour_inc_next;
    logic  min_inc_next;
    logic  sec_zero_next;

    // Priority: mode press swallows a/b in the same cycle; a swallows b.
    always_comb begin
        state_next      = state;
        start_stop_next = start_stop;
        clear_next      = 1'b0;
        hour_inc_next   = 1'b0;
        min_inc_next    = 1'b0;
        sec_zero_next   = 1'b0;
        if (press[2]) begin
            case (state)
                CLOCK:     state_next = STOPWATCH;
                STOPWATCH: state_next = SET_HOUR;
                SET_HOUR:  state_next = SET_MIN;
                default:   state_next = CLOCK;
            endcase
        end else if (press[0]) begin
            case (state)
                STOPWATCH: start_stop_next = ~start_stop;
                SET_HOUR:  hour_inc_next   = 1'b1;
                SET_MIN:   min_inc_next    = 1'b1;
                default:   ;
            endcase
        end else if (press[1]) begin
            case (state)
                STOPWATCH: clear_next    = ~start_stop;
                SET_HOUR:  sec_zero_next = 1'b1;
                SET_MIN:   sec_zero_next = 1'b1;
                default:   ;
            endcase
        end
    end

    logic [SC_W-1:0] scan_cnt;
    logic [SC_W-1:0] scan_cnt_next;
    logic [5:0]      sel_next;
    logic [BL_W-1:0] blink_cnt;
    logic [BL_W-1:0] blink_cnt_next;
    logic            blink_phase;
    logic            blink_phase_next;
    logic [3:0]      view_val;
    logic [3:0]      val_next;

    // digit_val is derived from the post-edge selection, mode and blink
    // phase so that value and select always change on the same edge.
    always_comb begin
        scan_cnt_next = scan_cnt + SC_W'(1);
        sel_next      = digit_sel;
        if (scan_cnt == SC_W'(SCAN_CYCLES - 1)) begin
            scan_cnt_next = '0;
            sel_next      = {digit_sel[0], digit_sel[5:1]};
        end

        blink_cnt_next   = blink_cnt + BL_W'(1);
        blink_phase_next = blink_phase;
        if (state_next != state) begin
            blink_cnt_next   = '0;
            blink_phase_next = 1'b1;
        end else if (blink_cnt == BL_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_next   = '0;
            blink_phase_next = ~blink_phase;
        end

        view_val = 4'hF;
        if (state_next == STOPWATCH) begin
            case (sel_next)
                6'b100000: view_val = 4'hF;
                6'b010000: view_val = {1'b0, min2_q};
                6'b001000: view_val = min1_q;
                6'b000100: view_val = {1'b0, sec2_q};
                6'b000010: view_val = sec1_q;
                6'b000001: view_val = point1_q;
                default:   view_val = 4'hF;
            endcase
        end else begin
            case (sel_next)
                6'b100000: view_val = {2'b00, hour2};
                6'b010000: view_val = hour1;
                6'b001000: view_val = {1'b0, min2};
                6'b000100: view_val = min1;
                6'b000010: view_val = {1'b0, sec2};
                6'b000001: view_val = sec1;
                default:   view_val = 4'hF;
            endcase
        end

        val_next = view_val;
        if (!blink_phase_next) begin
            if (state_next == SET_HOUR && (sel_next[5] || sel_next[4])) begin
                val_next = 4'hF;
            end
            if (state_next == SET_MIN && (sel_next[3] || sel_next[2])) begin
                val_next = 4'hF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= CLOCK;
            start_stop  <= 1'b0;
            clear       <= 1'b0;
            hour_inc    <= 1'b0;
            min_inc     <= 1'b0;
            sec_zero    <= 1'b0;
            scan_cnt    <= '0;
            digit_sel   <= 6'b100000;
            digit_val   <= 4'h0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            state       <= state_next;
            start_stop  <= start_stop_next;
            clear       <= clear_next;
            hour_inc    <= hour_inc_next;
            min_inc     <= min_inc_next;
            sec_zero    <= sec_zero_next;
            scan_cnt    <= scan_cnt_next;
            digit_sel   <= sel_next;
            digit_val   <= val_next;
            blink_cnt   <= blink_cnt_next;
            blink_phase <= blink_phase_next;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_watch_mode_controller.sv
// tb/tb_watch_mode_controller.sv - self-checking bench for watch_mode_controller
module tb_watch_mode_controller;

    localparam int D = 4;
    localparam int S = 2;
    localparam int B = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_a = 1'b0;
    logic       btn_b = 1'b0;
    logic [1:0] hour2 = 2'd2;
    logic [3:0] hour1 = 4'd3;
    logic [2:0] min2 = 3'd5;
    logic [3:0] min1 = 4'd9;
    logic [2:0] sec2 = 3'd4;
    logic [3:0] sec1 = 4'd7;
    logic [2:0] min2_q = 3'd1;
    logic [3:0] min1_q = 4'd2;
    logic [2:0] sec2_q = 3'd3;
    logic [3:0] sec1_q = 4'd4;
    logic [3:0] point1_q = 4'd5;
    logic       start_stop;
    logic       clear;
    logic       hour_inc;
    logic       min_inc;
    logic       sec_zero;
    logic [1:0] mode;
    logic [5:0] digit_sel;
    logic [3:0] digit_val;

    int errors = 0;
    int checks = 0;

    watch_mode_controller #(
        .DEBOUNCE_CYCLES(D),
        .SCAN_CYCLES(S),
        .BLINK_CYCLES(B)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_mode(btn_mode),
        .btn_a(btn_a),
        .btn_b(btn_b),
        .hour2(hour2),
        .hour1(hour1),
        .min2(min2),
        .min1(min1),
        .sec2(sec2),
        .sec1(sec1),
        .min2_q(min2_q),
        .min1_q(min1_q),
        .sec2_q(sec2_q),
        .sec1_q(sec1_q),
        .point1_q(point1_q),
        .start_stop(start_stop),
        .clear(clear),
        .hour_inc(hour_inc),
        .min_inc(min_inc),
        .sec_zero(sec_zero),
        .mode(mode),
        .digit_sel(digit_sel),
        .digit_val(digit_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw samples per edge, window-based debounce,
    // edge-count arithmetic for scan position and blink phase.
    logic [2:0] hist[$];
    int         e;
    int         e_mc;
    int         m_mode;
    logic       m_ss, m_clear, m_hinc, m_minc, m_szero;
    logic [2:0] m_acc;
    int         m_rise[3];
    logic [5:0] m_sel;
    logic [3:0] m_val;

    function automatic logic raw_at(int k, int b);
        if (k < 1) return 1'b0;
        return hist[k-1][b];
    endfunction

    function automatic logic [3:0] view_digit(int md, int p, logic ph);
        logic [3:0] v[6];
        if (md == 1) begin
            v[0] = 4'hF; v[1] = {1'b0, min2_q}; v[2] = min1_q;
            v[3] = {1'b0, sec2_q}; v[4] = sec1_q; v[5] = point1_q;
        end else begin
            v[0] = {2'b00, hour2}; v[1] = hour1; v[2] = {1'b0, min2};
            v[3] = min1; v[4] = {1'b0, sec2}; v[5] = sec1;
        end
        if (!ph && md == 2 && p < 2) return 4'hF;
        if (!ph && md == 3 && (p == 2 || p == 3)) return 4'hF;
        return v[p];
    endfunction

    task automatic model_reset();
        hist.delete();
        e = 0; e_mc = 0; m_mode = 0;
        m_ss = 0; m_clear = 0; m_hinc = 0; m_minc = 0; m_szero = 0;
        m_acc = '0;
        for (int b = 0; b < 3; b++) m_rise[b] = -100;
        m_sel = 6'b100000;
        m_val = 4'h0;
    endtask

    task automatic model_step();
        logic mis;
        logic pm, pa, pb;
        logic ph;
        int   p;
        logic [5:0] top;
        e++;
        hist.push_back({btn_mode, btn_b, btn_a});
        for (int b = 0; b < 3; b++) begin
            mis = 1'b1;
            for (int k = e - 1 - D; k <= e - 2; k++) begin
                if (raw_at(k, b) == m_acc[b]) mis = 1'b0;
            end
            if (mis) begin
                m_acc[b] = ~m_acc[b];
                if (m_acc[b]) m_rise[b] = e;
            end
        end
        pa = (m_rise[0] == e - 2);
        pb = (m_rise[1] == e - 2);
        pm = (m_rise[2] == e - 2);
        m_clear = 0; m_hinc = 0; m_minc = 0; m_szero = 0;
        if (pm) begin
            m_mode = (m_mode + 1) % 4;
            e_mc = e;
        end else if (pa) begin
            if (m_mode == 1) m_ss = ~m_ss;
            else if (m_mode == 2) m_hinc = 1;
            else if (m_mode == 3) m_minc = 1;
        end else if (pb) begin
            if (m_mode == 1) m_clear = ~m_ss;
            else if (m_mode >= 2) m_szero = 1;
        end
        p = (e / S) % 6;
        top = 6'b100000;
        m_sel = top >> p;
        ph = (((e - e_mc) / B) % 2) == 0;
        m_val = view_digit(m_mode, p, ph);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    int n_clear = 0, n_hinc = 0, n_minc = 0, n_szero = 0;

    initial begin
        forever begin
            @(negedge clk);
            check("mode", mode, m_mode);
            check("start_stop", start_stop, m_ss);
            check("clear", clear, m_clear);
            check("hour_inc", hour_inc, m_hinc);
            check("min_inc", min_inc, m_minc);
            check("sec_zero", sec_zero, m_szero);
            check("digit_sel", digit_sel, m_sel);
            check("digit_val", digit_val, m_val);
            if (clear) n_clear++;
            if (hour_inc) n_hinc++;
            if (min_inc) n_minc++;
            if (sec_zero) n_szero++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mask bit0 = a, bit1 = b, bit2 = mode
    task automatic press(input logic [2:0] m);
        @(negedge clk);
        btn_a = m[0]; btn_b = m[1]; btn_mode = m[2];
        cycles(12);
        btn_a = 0; btn_b = 0; btn_mode = 0;
        cycles(12);
        #1;
    endtask

    initial begin
        int mseq[4];
        int dv[6];
        int prev;
        int c0;
        logic [5:0] top;
        mseq = '{1, 2, 3, 0};
        dv = '{2, 3, 5, 9, 4, 7};
        top = 6'b100000;

        cycles(2);
        #1;
        check("rst_mode", mode, 0);
        check("rst_sel", digit_sel, 6'b100000);
        check("rst_val", digit_val, 0);
        check("rst_ss", start_stop, 0);
        @(negedge clk);
        rst = 1;

        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            #1;
            check("scan_sel", digit_sel, top >> ((k / 2) % 6));
            check("scan_val", digit_val, dv[(k / 2) % 6]);
        end

        for (int i = 0; i < 4; i++) begin
            prev = (i == 0) ? 0 : mseq[i-1];
            @(negedge clk);
            btn_mode = 1;
            repeat (7) @(posedge clk);
            #1 check("mode_before_edge8", mode, prev);
            @(posedge clk);
            #1 check("mode_at_edge8", mode, mseq[i]);
            cycles(12);
            btn_mode = 0;
            cycles(20);
        end

        press(3'b100);
        check("enter_sw", mode, 1);
        press(3'b001);
        check("sw_start", start_stop, 1);
        c0 = n_clear;
        press(3'b010);
        check("sw_clear_ignored", n_clear - c0, 0);
        press(3'b001);
        check("sw_stop", start_stop, 0);
        c0 = n_clear;
        press(3'b010);
        check("sw_clear_pulse", n_clear - c0, 1);

        for (int g = 0; g < 10; g++) begin
            @(negedge clk); btn_a = 1;
            @(negedge clk); btn_a = 0;
            @(negedge clk);
        end
        cycles(12);
        #1 check("glitch_no_press", start_stop, 0);

        c0 = n_clear;
        press(3'b011);
        check("ab_a_wins", start_stop, 1);
        check("ab_b_dropped", n_clear - c0, 0);

        press(3'b100);
        check("enter_set_hour", mode, 2);
        c0 = n_hinc;
        press(3'b101);
        check("mode_wins", mode, 3);
        check("mode_wins_no_hinc", n_hinc - c0, 0);
        c0 = n_minc;
        press(3'b001);
        check("set_min_inc", n_minc - c0, 1);
        c0 = n_szero;
        press(3'b010);
        check("set_sec_zero", n_szero - c0, 1);

        @(posedge clk);
        #2 rst = 0;
        #1;
        check("arst_mode", mode, 0);
        check("arst_ss", start_stop, 0);
        check("arst_sel", digit_sel, 6'b100000);
        check("arst_val", digit_val, 0);
        check("arst_pulses", {clear, hour_inc, min_inc, sec_zero}, 0);
        cycles(3);
        rst = 1;
        cycles(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
